// File: rtl/pixel_controller.sv
// pixel_controller
//
// Sequencer between the image-processing core and an off-chip 24-bit RGB pixel SRAM.
// A run is started by `enable` while idle. It first writes up to MAX_PIX grayscale pixels
// (replicated into all three colour bytes) to consecutive SRAM words. It then reads up to
// MAX_PIX consecutive RGB words, converts each one to 8-bit grayscale and strobes `read_now`
// once per pixel. After a run the block parks in DONE until reset.
//
// Ports:
//   clk                  - system clock, all state on the rising edge
//   n_rst                - synchronous reset, active-high despite the name
//   enable               - start request, only looked at while idle
//   data_in              - grayscale pixels to write, element i -> write offset + i
//   address_write_offset - first SRAM address written
//   address_read_offset  - first SRAM address read
//   num_pix_write        - pixels to write (clamped to MAX_PIX)
//   num_pix_read         - pixels to read (clamped to MAX_PIX)
//   data_out             - grayscale results, element i <- read offset + i
//   read_now             - one-cycle strobe, data_out[i] newly valid
//   address              - SRAM address
//   w_data               - SRAM write data
//   r_data               - SRAM read data, valid while read_enable is high
//   read_enable          - SRAM read strobe
//   write_enable         - SRAM write strobe
module pixel_controller #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned MAX_PIX   = 20
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          enable,
    input  logic [MAX_PIX-1:0][7:0]       data_in,
    input  logic [ADDR_BITS-1:0]          address_write_offset,
    input  logic [ADDR_BITS-1:0]          address_read_offset,
    input  logic [24:0]                   num_pix_write,
    input  logic [24:0]                   num_pix_read,
    output logic [MAX_PIX-1:0][7:0]       data_out,
    output logic                          read_now,
    output logic [ADDR_BITS-1:0]          address,
    output logic [23:0]                   w_data,
    input  logic [23:0]                   r_data,
    output logic                          read_enable,
    output logic                          write_enable
);

    localparam int unsigned CW = $clog2(MAX_PIX + 1);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] WR_SETUP   = 4'd1;
    localparam logic [3:0] WR_PULSE1  = 4'd2;
    localparam logic [3:0] WR_PULSE2  = 4'd3;
    localparam logic [3:0] WR_HOLD    = 4'd4;
    localparam logic [3:0] RD_ADDR    = 4'd5;
    localparam logic [3:0] RD_WAIT    = 4'd6;
    localparam logic [3:0] RD_CAPTURE = 4'd7;
    localparam logic [3:0] RD_PRESENT = 4'd8;
    localparam logic [3:0] DONE       = 4'd9;

    function automatic logic [CW-1:0] clamp_count(input logic [24:0] n);
        if (n > 25'(MAX_PIX)) begin
            return CW'(MAX_PIX);
        end
        return CW'(n);
    endfunction

    logic [3:0]               state_q, state_d;
    logic [CW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            idx_inc;
    logic [CW-1:0]            w_cnt_q, r_cnt_q;
    logic [CW-1:0]            w_cnt_start, r_cnt_start;
    logic [ADDR_BITS-1:0]     wr_off_q, rd_off_q;
    logic [MAX_PIX-1:0][7:0]  pix_q;
    logic [MAX_PIX-1:0][7:0]  data_out_q;
    logic                     start;

    logic [ADDR_BITS-1:0]     wr_base, rd_base;
    logic [7:0]               pix_cur;
    logic [ADDR_BITS-1:0]     address_q, address_d;
    logic [23:0]              w_data_q, w_data_d;
    logic                     re_q, re_d;
    logic                     we_q, we_d;
    logic                     rn_q, rn_d;

    logic [9:0]               gray_sum;
    logic [7:0]               gray_px;

    assign start       = (state_q == IDLE) && enable;
    assign w_cnt_start = clamp_count(num_pix_write);
    assign r_cnt_start = clamp_count(num_pix_read);
    assign idx_inc     = idx_q + CW'(1);

    // On the start edge the run parameters are not latched yet, so take them from the ports.
    assign wr_base = (state_q == IDLE) ? address_write_offset : wr_off_q;
    assign rd_base = (state_q == IDLE) ? address_read_offset  : rd_off_q;
    assign pix_cur = (state_q == IDLE) ? data_in[idx_d]       : pix_q[idx_d];

    // (R + 2G + B) >> 2; the 10-bit sum cannot overflow, so the result fits in 8 bits.
    assign gray_sum = {2'b00, r_data[23:16]} + {1'b0, r_data[15:8], 1'b0} + {2'b00, r_data[7:0]};
    assign gray_px  = 8'(gray_sum >> 2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    idx_d = '0;
                    if (w_cnt_start != '0) begin
                        state_d = WR_SETUP;
                    end else if (r_cnt_start != '0) begin
                        state_d = RD_ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WR_SETUP:  state_d = WR_PULSE1;
            WR_PULSE1: state_d = WR_PULSE2;
            WR_PULSE2: state_d = WR_HOLD;
            WR_HOLD: begin
                if (idx_inc == w_cnt_q) begin
                    idx_d   = '0;
                    state_d = (r_cnt_q != '0) ? RD_ADDR : DONE;
                end else begin
                    idx_d   = idx_inc;
                    state_d = WR_SETUP;
                end
            end
            RD_ADDR:    state_d = RD_WAIT;
            RD_WAIT:    state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = RD_PRESENT;
            RD_PRESENT: begin
                if (idx_inc == r_cnt_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_inc;
                    state_d = RD_ADDR;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered: they are computed from the state being entered.
    always_comb begin
        address_d = address_q;
        w_data_d  = w_data_q;
        re_d      = 1'b0;
        we_d      = 1'b0;
        rn_d      = 1'b0;
        unique case (state_d)
            WR_SETUP: begin
                address_d = wr_base + ADDR_BITS'(idx_d);
                w_data_d  = {3{pix_cur}};
            end
            WR_PULSE1, WR_PULSE2: we_d = 1'b1;
            WR_HOLD: begin
            end
            RD_ADDR: begin
                address_d = rd_base + ADDR_BITS'(idx_d);
                w_data_d  = '0;
                re_d      = 1'b1;
            end
            RD_WAIT, RD_CAPTURE: re_d = 1'b1;
            RD_PRESENT: rn_d = 1'b1;
            default: begin
                address_d = '0;
                w_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            w_cnt_q    <= '0;
            r_cnt_q    <= '0;
            wr_off_q   <= '0;
            rd_off_q   <= '0;
            pix_q      <= '0;
            data_out_q <= '0;
            address_q  <= '0;
            w_data_q   <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            rn_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            address_q <= address_d;
            w_data_q  <= w_data_d;
            re_q      <= re_d;
            we_q      <= we_d;
            rn_q      <= rn_d;
            if (start) begin
                w_cnt_q  <= w_cnt_start;
                r_cnt_q  <= r_cnt_start;
                wr_off_q <= address_write_offset;
                rd_off_q <= address_read_offset;
                pix_q    <= data_in;
            end
            if (state_q == RD_CAPTURE) begin
                data_out_q[idx_q] <= gray_px;
            end
        end
    end

    assign data_out     = data_out_q;
    assign read_now     = rn_q;
    assign address      = address_q;
    assign w_data       = w_data_q;
    assign read_enable  = re_q;
    assign write_enable = we_q;

endmodule

// File: tb/tb_pixel_controller.sv
// Directed bench for pixel_controller with a behavioural SRAM and a negedge bus monitor.
module tb_pixel_controller;

    logic              clk = 1'b0;
    logic              n_rst = 1'b1;
    logic              enable = 1'b0;
    logic [19:0][7:0]  data_in = '0;
    logic [15:0]       address_write_offset = '0;
    logic [15:0]       address_read_offset = '0;
    logic [24:0]       num_pix_write = '0;
    logic [24:0]       num_pix_read = '0;
    logic [19:0][7:0]  data_out;
    logic              read_now;
    logic [15:0]       address;
    logic [23:0]       w_data;
    logic [23:0]       r_data;
    logic              read_enable;
    logic              write_enable;

    always #5 clk = ~clk;

    pixel_controller #(
        .ADDR_BITS (16),
        .MAX_PIX   (20)
    ) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .enable               (enable),
        .data_in              (data_in),
        .address_write_offset (address_write_offset),
        .address_read_offset  (address_read_offset),
        .num_pix_write        (num_pix_write),
        .num_pix_read         (num_pix_read),
        .data_out             (data_out),
        .read_now             (read_now),
        .address              (address),
        .w_data               (w_data),
        .r_data               (r_data),
        .read_enable          (read_enable),
        .write_enable         (write_enable)
    );

    // Behavioural SRAM with a bench-side preload port.
    logic [23:0] sram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [23:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (write_enable) sram[address] <= w_data;
    end
    assign r_data = read_enable ? sram[address] : 24'h0;

    // Cycle counter and bus monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               overlap = 0;
    int               we_cycles = 0;
    int               act = 0;
    int               rn_count = 0;
    int               ra_n = 0;
    int               rn_cyc [64];
    logic [19:0][7:0] rn_snap [64];
    logic [15:0]      rd_addr [64];
    logic             re_prev = 1'b0;

    always @(negedge clk) begin
        if (read_enable && write_enable) overlap <= overlap + 1;
        if (write_enable) we_cycles <= we_cycles + 1;
        if (read_enable || write_enable || read_now) act <= act + 1;
        if (read_now) begin
            if (rn_count < 64) begin
                rn_cyc[rn_count]  <= cyc;
                rn_snap[rn_count] <= data_out;
            end
            rn_count <= rn_count + 1;
        end
        if (read_enable && !re_prev) begin
            if (ra_n < 64) rd_addr[ra_n] <= address;
            ra_n <= ra_n + 1;
        end
        re_prev <= read_enable;
    end

    int total = 0;
    int passed = 0;
    int start_cyc, base_rn, base_we, base_act, base_ra;

    // Test A SRAM contents at 5..19 and their grayscale values.
    logic [23:0] words [15] = '{24'h102030, 24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00,
                                24'h0000FF, 24'h808080, 24'h010203, 24'h123456, 24'hFF00FF,
                                24'h7F7F7F, 24'h030303, 24'h400000, 24'h000001, 24'h01FF02};
    logic [7:0]  grays [15] = '{8'h20, 8'hFF, 8'h00, 8'h3F, 8'h7F,
                                8'h3F, 8'h80, 8'h02, 8'h34, 8'h7F,
                                8'h7F, 8'h03, 8'h10, 8'h00, 8'h80};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [23:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
    endtask

    // Drives enable in cycle 1 of the run; returns at the negedge of cycle 2.
    task automatic start_run(input int w, input int r, input logic [15:0] wo,
                             input logic [15:0] ro, input bit hold);
        @(negedge clk);
        num_pix_write        = 25'(w);
        num_pix_read         = 25'(r);
        address_write_offset = wo;
        address_read_offset  = ro;
        enable               = 1'b1;
        start_cyc = cyc;
        base_rn   = rn_count;
        base_we   = we_cycles;
        base_act  = act;
        base_ra   = ra_n;
        @(negedge clk);
        if (!hold) enable = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 13 + 1);
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        check("rst_address", address, 0);
        check("rst_w_data", w_data, 0);
        check("rst_read_enable", read_enable, 0);
        check("rst_write_enable", write_enable, 0);
        check("rst_read_now", read_now, 0);
        check("rst_data_out", 32'(|data_out), 0);

        // Test A: W=3 then R=15 from offset 5
        for (int i = 0; i < 15; i++) preload(16'(5 + i), words[i]);
        data_in[0] = 8'hE0;
        data_in[1] = 8'hFE;
        data_in[2] = 8'hE9;
        start_run(3, 15, 16'h0000, 16'h0005, 1'b0);
        // Changes after start must not affect the run.
        data_in              = {20{8'h55}};
        address_write_offset = 16'h1234;
        address_read_offset  = 16'h4321;
        num_pix_write        = '0;
        num_pix_read         = '0;
        repeat (75) @(negedge clk);
        check("a_sram0", sram[0], 24'hE0E0E0);
        check("a_sram1", sram[1], 24'hFEFEFE);
        check("a_sram2", sram[2], 24'hE9E9E9);
        check("a_we_cycles", we_cycles - base_we, 6);
        check("a_pulses", rn_count - base_rn, 15);
        check("a_first_pulse", rn_cyc[base_rn] - start_cyc + 1, 17);
        check("a_last_pulse", rn_cyc[base_rn + 14] - start_cyc + 1, 73);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("a_gray%0d", i), rn_snap[base_rn + i][i], grays[i]);
        end
        check("a_untouched15", data_out[15], 0);
        check("a_untouched19", data_out[19], 0);
        check("a_held0", data_out[0], 8'h20);
        check("a_done_address", address, 0);
        check("a_done_re", read_enable, 0);

        // Reset in the middle of a read run
        do_reset();
        start_run(0, 3, 16'h0000, 16'h0005, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_data0", data_out[0], 8'h20);
        check("mid_re", read_enable, 1);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_re", read_enable, 0);
        check("mid_rst_rn", read_now, 0);
        check("mid_rst_address", address, 0);
        check("mid_rst_data_out", 32'(|data_out), 0);
        n_rst = 1'b0;

        // W=0, R=2 from offset 8 (FF0000, 00FF00)
        start_run(0, 2, 16'h0000, 16'h0008, 1'b0);
        repeat (12) @(negedge clk);
        check("z_we_cycles", we_cycles - base_we, 0);
        check("z_pulses", rn_count - base_rn, 2);
        check("z_first_pulse", rn_cyc[base_rn] - start_cyc + 1, 5);
        check("z_gray0", data_out[0], 8'h3F);
        check("z_gray1", data_out[1], 8'h7F);
        check("z_untouched2", data_out[2], 0);

        // W=0, R=0: straight to DONE, no strobes even with enable held
        do_reset();
        start_run(0, 0, 16'h0000, 16'h0000, 1'b1);
        repeat (20) @(negedge clk);
        check("n_activity", act - base_act, 0);

        // Clamp: W=25, R=25 at 0x100, reading back what was written
        do_reset();
        preload(16'h0114, 24'hABCDEF);
        for (int i = 0; i < 20; i++) data_in[i] = pat(i);
        start_run(25, 25, 16'h0100, 16'h0100, 1'b0);
        repeat (165) @(negedge clk);
        check("c_pulses", rn_count - base_rn, 20);
        check("c_first_pulse", rn_cyc[base_rn] - start_cyc + 1, 85);
        check("c_last_pulse", rn_cyc[base_rn + 19] - start_cyc + 1, 161);
        check("c_we_cycles", we_cycles - base_we, 40);
        check("c_sram_first", sram[16'h0100], {3{pat(0)}});
        check("c_sram_last", sram[16'h0113], {3{pat(19)}});
        check("c_sram_beyond", sram[16'h0114], 24'hABCDEF);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("c_data%0d", i), data_out[i], pat(i));
        end

        // Address wrap, then DONE holds with enable high
        do_reset();
        preload(16'hFFFE, 24'hFFFFFF);
        preload(16'hFFFF, 24'h000000);
        start_run(0, 4, 16'h0000, 16'hFFFE, 1'b1);
        repeat (25) @(negedge clk);
        check("w_addr_count", ra_n - base_ra, 4);
        check("w_addr0", rd_addr[base_ra], 16'hFFFE);
        check("w_addr1", rd_addr[base_ra + 1], 16'hFFFF);
        check("w_addr2", rd_addr[base_ra + 2], 16'h0000);
        check("w_addr3", rd_addr[base_ra + 3], 16'h0001);
        check("w_data0", data_out[0], 8'hFF);
        check("w_data1", data_out[1], 8'h00);
        check("w_data2", data_out[2], 8'hE0);
        check("w_data3", data_out[3], 8'hFE);
        base_act = act;
        repeat (30) @(negedge clk);
        check("w_done_activity", act - base_act, 0);
        check("w_done_address", address, 0);

        check("strobe_overlap", overlap, 0);
        enable = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
